// File: rtl/lab4_net_router_output_ctrl.sv
// Ring-router output-port controller: round-robin grant among west/terminal/east, gated by downstream credits.
// Optional counters are built when LAB4_NET_ROUTER_OUTPUT_CTRL_STATS_EN is defined.
module lab4_net_router_output_ctrl #(
    parameter int p_num_credits    = 2,
    parameter int p_num_free_nbits = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [2:0]                  reqs,
    output logic [2:0]                  grants,
    output logic [1:0]                  xbar_sel,
    output logic                        out_val,
    input  logic                        credit_ret,
    output logic [p_num_free_nbits-1:0] num_free,
    output logic                        credit_err,
    output logic [15:0]                 stat_grants,
    output logic [15:0]                 stat_stalls
);

    localparam logic [p_num_free_nbits-1:0] CRED_MAX = p_num_free_nbits'(p_num_credits);
    localparam logic [p_num_free_nbits-1:0] CRED_ONE = p_num_free_nbits'(1);

    logic [2:0]                  prio;
    logic [p_num_free_nbits-1:0] credits;
    logic [1:0]                  prio_idx;
    logic [2:0]                  cand;
    logic [1:0]                  win;
    logic                        found;

    assign prio_idx = prio[1] ? 2'd1 : (prio[2] ? 2'd2 : 2'd0);

    // Circular scan starting at the priority pointer; first requester found wins.
    always_comb begin
        cand  = 3'd0;
        win   = 2'd0;
        found = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cand = {1'b0, prio_idx} + 3'(k);
            if (cand >= 3'd3) cand = cand - 3'd3;
            if (!found && reqs[cand[1:0]]) begin
                found = 1'b1;
                win   = cand[1:0];
            end
        end
    end

    always_comb begin
        grants   = 3'b000;
        xbar_sel = 2'd0;
        out_val  = 1'b0;
        if (reset && credits != '0 && found) begin
            grants   = 3'b001 << win;
            xbar_sel = win;
            out_val  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            prio       <= 3'b001;
            credits    <= CRED_MAX;
            credit_err <= 1'b0;
        end else begin
            if (out_val)
                prio <= {grants[1:0], grants[2]};
            if (out_val && !credit_ret)
                credits <= credits - CRED_ONE;
            else if (!out_val && credit_ret) begin
                // A return with the queue already fully credited is a protocol error; saturate.
                if (credits == CRED_MAX)
                    credit_err <= 1'b1;
                else
                    credits <= credits + CRED_ONE;
            end
        end
    end

    assign num_free = credits;

`ifdef LAB4_NET_ROUTER_OUTPUT_CTRL_STATS_EN
    logic [15:0] grant_cnt;
    logic [15:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            grant_cnt <= 16'd0;
            stall_cnt <= 16'd0;
        end else begin
            if (out_val && grant_cnt != 16'hFFFF)
                grant_cnt <= grant_cnt + 16'd1;
            if (reqs != 3'b000 && credits == '0 && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign stat_grants = grant_cnt;
    assign stat_stalls = stall_cnt;
`else
    assign stat_grants = 16'd0;
    assign stat_stalls = 16'd0;
`endif

endmodule

// File: tb/tb_lab4_net_router_output_ctrl.sv
// Scoreboard bench: stimulus pushes hand-computed per-cycle expectations, a negedge monitor pops and checks.
module tb_lab4_net_router_output_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  reqs;
    logic [2:0]  grants;
    logic [1:0]  xbar_sel;
    logic        out_val;
    logic        credit_ret;
    logic [1:0]  num_free;
    logic        credit_err;
    logic [15:0] stat_grants;
    logic [15:0] stat_stalls;

    always #5 clk = ~clk;

    lab4_net_router_output_ctrl #(.p_num_credits(2), .p_num_free_nbits(2)) dut (
        .clk(clk), .reset(reset), .reqs(reqs), .grants(grants), .xbar_sel(xbar_sel),
        .out_val(out_val), .credit_ret(credit_ret), .num_free(num_free),
        .credit_err(credit_err), .stat_grants(stat_grants), .stat_stalls(stat_stalls)
    );

    typedef struct packed {
        logic [2:0]  g;
        logic [1:0]  sel;
        logic        v;
        logic [1:0]  nf;
        logic        err;
        logic [15:0] st;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_no  = 0;

    task automatic chk(input string name, input int n, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, n, act, exp);
        end
    endtask

    // Monitor: the grant path is combinational, so every cycle presents an output to check.
    int mon_n = 0;
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            logic [15:0] exp_st;
            e = q.pop_front();
            mon_n++;
`ifdef LAB4_NET_ROUTER_OUTPUT_CTRL_STATS_EN
            exp_st = e.st;
`else
            exp_st = 16'd0;
            chk("stat_grants", mon_n, int'(stat_grants), 0);
`endif
            chk("grants",     mon_n, int'(grants),     int'(e.g));
            chk("xbar_sel",   mon_n, int'(xbar_sel),   int'(e.sel));
            chk("out_val",    mon_n, int'(out_val),    int'(e.v));
            chk("num_free",   mon_n, int'(num_free),   int'(e.nf));
            chk("credit_err", mon_n, int'(credit_err), int'(e.err));
            chk("stat_stalls", mon_n, int'(stat_stalls), int'(exp_st));
        end
    end

    task automatic step(input logic r, input logic [2:0] rq, input logic c,
                        input logic [2:0] g, input logic [1:0] s, input logic v,
                        input logic [1:0] nf, input logic e, input logic [15:0] st);
        exp_t x;
        @(posedge clk);
        #1;
        reset      = r;
        reqs       = rq;
        credit_ret = c;
        x = '{g: g, sel: s, v: v, nf: nf, err: e, st: st};
        q.push_back(x);
        step_no++;
    endtask

    initial begin
        reset = 1'b0; reqs = 3'b000; credit_ret = 1'b0;
        //     rst reqs    cr  grants  sel v  nf e  stalls
        // reset, then idle
        step(0, 3'b111, 0, 3'b000, 0, 0, 2, 0, 0);
        step(0, 3'b000, 0, 3'b000, 0, 0, 2, 0, 0);
        step(1, 3'b000, 0, 3'b000, 0, 0, 2, 0, 0);
        // round robin, all requesting, credit returned from cycle 1
        step(1, 3'b111, 0, 3'b001, 0, 1, 2, 0, 0);
        step(1, 3'b111, 1, 3'b010, 1, 1, 1, 0, 0);
        step(1, 3'b111, 1, 3'b100, 2, 1, 1, 0, 0);
        step(1, 3'b111, 1, 3'b001, 0, 1, 1, 0, 0);
        step(1, 3'b111, 1, 3'b010, 1, 1, 1, 0, 0);
        step(1, 3'b111, 1, 3'b100, 2, 1, 1, 0, 0);
        step(1, 3'b000, 1, 3'b000, 0, 0, 1, 0, 0);
        // credit exhaustion on terminal; returned credit usable only the next cycle
        step(1, 3'b010, 0, 3'b010, 1, 1, 2, 0, 0);
        step(1, 3'b010, 0, 3'b010, 1, 1, 1, 0, 0);
        step(1, 3'b010, 0, 3'b000, 0, 0, 0, 0, 0);
        step(1, 3'b010, 1, 3'b000, 0, 0, 0, 0, 1);
        step(1, 3'b010, 0, 3'b010, 1, 1, 1, 0, 2);
        // skip over non-requesting east, pointer then moves to index 1
        step(1, 3'b000, 1, 3'b000, 0, 0, 0, 0, 2);
        step(1, 3'b011, 1, 3'b001, 0, 1, 1, 0, 2);
        step(1, 3'b011, 0, 3'b010, 1, 1, 1, 0, 2);
        // grant and credit return in the same cycle
        step(1, 3'b000, 1, 3'b000, 0, 0, 0, 0, 2);
        step(1, 3'b100, 1, 3'b100, 2, 1, 1, 0, 2);
        step(1, 3'b000, 0, 3'b000, 0, 0, 1, 0, 2);
        // overflow: sticky error, credits saturate
        step(1, 3'b000, 1, 3'b000, 0, 0, 1, 0, 2);
        step(1, 3'b000, 1, 3'b000, 0, 0, 2, 0, 2);
        step(1, 3'b000, 0, 3'b000, 0, 0, 2, 1, 2);
        step(1, 3'b000, 0, 3'b000, 0, 0, 2, 1, 2);
        // mid-operation reset with everyone requesting
        step(0, 3'b111, 1, 3'b000, 0, 0, 2, 1, 2);
        step(1, 3'b111, 0, 3'b001, 0, 1, 2, 0, 0);
        step(1, 3'b111, 0, 3'b010, 1, 1, 1, 0, 0);
        step(1, 3'b000, 0, 3'b000, 0, 0, 0, 0, 0);

        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "timeout");
    end

endmodule
